adc_scan_avg: RTL

//   Downstream consumer of adc_capture. Drives its adc_ack/address handshake to round-robin

---
 rtl/adc_scan_avg.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/adc_scan_avg.sv
// Round-robin scanner for the 8-channel SPI ADC behind adc_capture: tags each returned
// sample with the channel issued two acks earlier and averages 2^AVG_LOG2 samples per channel.
module adc_scan_avg #(
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  localparam int AW      = $clog2(NUM_CH)
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en_mask,
  input  logic              adc_ready,
  input  logic [DATA_W-1:0] d_signal,
  output logic              adc_ack,
  output logic [AW-1:0]     address,
  output logic              sample_strobe,
  output logic [AW-1:0]     sample_ch,
  input  logic [AW-1:0]     rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_RDY, S_ACK, S_WAIT_LOW} state_t;

  state_t              r_state;
  logic                r_ack;
  logic [AW-1:0]       r_addr;
  logic [1:0]          r_prime;
  logic [AW-1:0]       r_tag_p0;
  logic [AW-1:0]       r_tag_p1;
  logic [ACC_W-1:0]    r_acc [NUM_CH];
  logic [CNT_W-1:0]    r_cnt [NUM_CH];
  logic [DATA_W-1:0]   r_result [NUM_CH];
  logic [NUM_CH-1:0]   r_valid;
  logic                r_strobe;
  logic [AW-1:0]       r_sample_ch;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;

  logic                w_take;
  logic                w_last;
  logic [ACC_W-1:0]    w_sum;

  // First enabled channel strictly above cur (wrapping); cur itself if it is the only one.
  function automatic logic [AW-1:0] f_next_ch(input logic [AW-1:0] cur,
                                              input logic [NUM_CH-1:0] mask);
    logic [AW-1:0] nxt;
    logic          found;
    logic [AW-1:0] c;
    nxt   = cur;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = AW'((int'(cur) + i) % NUM_CH);
      if (!found && mask[c]) begin
        nxt   = c;
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

  function automatic logic [DATA_W-1:0] f_avg_trunc(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1:AVG_LOG2];
  endfunction

  assign w_take = (r_state == S_ACK) && (r_prime == 2'd0) && en_mask[r_tag_p1];
  assign w_last = (r_cnt[r_tag_p1] == CNT_LAST);
  assign w_sum  = r_acc[r_tag_p1] + ACC_W'(d_signal);

  // p0: handshake FSM; tag pipe shifts on every ack
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ack    <= 1'b0;
      r_addr   <= '0;
      r_prime  <= 2'd0;
      r_tag_p0 <= '0;
      r_tag_p1 <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_addr <= '0;
          if (|en_mask) begin
            r_addr  <= f_next_ch(AW'(NUM_CH - 1), en_mask);
            r_prime <= 2'd2;
            r_state <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (adc_ready) begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_addr   <= f_next_ch(r_addr, en_mask);
          r_tag_p0 <= r_addr;
          r_tag_p1 <= r_tag_p0;
          if (r_prime != 2'd0) r_prime <= r_prime - 2'd1;
          r_state  <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!adc_ready) r_state <= (|en_mask) ? S_WAIT_RDY : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // p1: accumulate tagged samples, publish averages, registered read port
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i]    <= '0;
        r_cnt[i]    <= '0;
        r_result[i] <= '0;
      end
      r_valid     <= '0;
      r_strobe    <= 1'b0;
      r_sample_ch <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_strobe <= w_take && w_last;
      if (w_take) begin
        if (w_last) begin
          r_result[r_tag_p1] <= f_avg_trunc(w_sum);
          r_valid[r_tag_p1]  <= 1'b1;
          r_acc[r_tag_p1]    <= '0;
          r_cnt[r_tag_p1]    <= '0;
          r_sample_ch        <= r_tag_p1;
        end else begin
          r_acc[r_tag_p1] <= w_sum;
          r_cnt[r_tag_p1] <= r_cnt[r_tag_p1] + CNT_W'(1);
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!en_mask[i]) begin
          r_acc[i]   <= '0;
          r_cnt[i]   <= '0;
          r_valid[i] <= 1'b0;
        end
      end
      r_rd_data  <= r_result[rd_ch];
      r_rd_valid <= r_valid[rd_ch];
    end
  end

  assign adc_ack       = r_ack;
  assign address       = r_addr;
  assign sample_strobe = r_strobe;
  assign sample_ch     = r_sample_ch;
  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;

endmodule
